rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter with hold, done-handshake and hold-timeout.
- Shares one resource (e.g. a bank or bus slot) between four clients.
- Emits an encoded owner index plus a one-hot grant; the one-hot grant is produced by the existing 2-to-4 decoder.
- Sits between client request lines and any datapath selected by a one-hot enable.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced release; legal range 1..31.
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  per-client request, level; bit i = client i.
- done  in  1  single-cycle release pulse from the current owner; ignored unless busy=1.
- grant  out  4  one-hot grant, decoded from grant_idx; all-zero when not busy.
- grant_idx  out  2  encoded owner index; valid only when busy=1.
- busy  out  1  high while in GRANT state.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (rst_n=0, async, no clock needed):
  - grant=0000, grant_idx=00, busy=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- States: IDLE, GRANT, RELEASE. All outputs are registered; grant is a combinational decode of registered grant_idx gated by busy.
- IDLE, req!=0:
  - Select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the edge: grant_idx=winner, busy=1, counter=1, go to GRANT.
  - Latency: request sampled at edge N, grant visible after edge N.
- IDLE, req==0: stay in IDLE; outputs unchanged (grant=0000).
- GRANT: grant held stable. At each edge, check in priority order:
  - done=1: release; timeout stays 0. Done has priority over timeout on the same cycle.
  - req[owner]=0: release, treated as done.
  - counter==MAX_HOLD: release and set timeout=1 for exactly one cycle.
  - Otherwise: counter+1; stay in GRANT.
- On any release:
  - busy=0, grant=0000, ptr=(owner+1) mod 4 with 2-bit wrap (owner 3 gives ptr 0), counter=0.
  - Go to RELEASE.
- RELEASE: one mandatory dead cycle with no grant; timeout clears; next edge goes to IDLE.
- Maximum continuous ownership is MAX_HOLD cycles. Minimum gap between grants is 2 cycles (RELEASE plus IDLE arbitration).
- Changes to req from non-owners during GRANT have no effect until the next IDLE evaluation.
- A done pulse while not busy is ignored.
- Reset asserted mid-GRANT drops grant to 0000 immediately and forgets ptr.
- Counter never exceeds MAX_HOLD; no wrap is possible.

Decomposition:
- Shared header with the state encodings (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2) and the NUM_REQ=4 constant, included by the RTL and the bench.
- One sub-module: decoder_2to4 instance converting grant_idx to the pre-gating one-hot grant.
- Priority search and counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with req=1111 -> grant=0000, busy=0, timeout=0. Release reset and hold req=0000 -> outputs unchanged.
- Single grant:
  - req=0001 at edge N -> grant=0001, grant_idx=00, busy=1 after edge N.
  - done pulse -> grant=0000 next edge; re-grant no sooner than 2 cycles later.
- Round-robin fairness: req=1111 held, done pulsed on each first grant cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with 2 idle cycles between grants.
- Timeout (MAX_HOLD=4):
  - req=0100 held, no done -> grant=0100 for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0000.
  - Then req=1100 -> grant=1000 (ptr=3).
- Done and timeout collide (MAX_HOLD=4): done asserted on the 4th grant cycle -> release with timeout=0. Owner drops req instead -> same result.
- Async reset mid-grant: grant=0010 active, pull rst_n low between edges -> grant=0000, busy=0 immediately. After release with req=0011 -> grant=0001 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-client round-robin arbiter: state encodings
// and requester count, imported by the RTL and its bench.
package rr_arbiter_4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage : rr_arbiter_4_pkg

// File: rtl/rr_arbiter_4_if.sv
// Client-side request/grant bundle of the round-robin arbiter.
interface rr_arbiter_4_if;
    import rr_arbiter_4_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               busy;
    logic               timeout;

    // master: the clients; slave: the arbiter
    modport master (
        output req, done,
        input  grant, grant_idx, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, busy, timeout
    );

endinterface : rr_arbiter_4_if

// File: rtl/rr_arbiter_4_decoder.sv
// 2-to-4 one-hot decoder used to form the arbiter grant vector.
module decoder_2to4 (
    input  logic [1:0] sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule : decoder_2to4

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold, done handshake and hold
// timeout; owner index and flags are registered, grant is decoded from them.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_4_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   hold_cnt;
    logic [IDX_W-1:0]   grant_idx_q;
    logic               busy_q;
    logic               timeout_q;
    logic [IDX_W-1:0]   winner;
    logic [NUM_REQ-1:0] onehot;
    logic               owner_req;
    logic               release_now;

    // First requester found scanning upward from ptr with 2-bit wrap
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign owner_req   = bus.req[grant_idx_q];
    assign release_now = bus.done || !owner_req || (hold_cnt == HOLD_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_idx_q <= winner;
                        busy_q      <= 1'b1;
                        hold_cnt    <= CNT_W'(1);
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        busy_q    <= 1'b0;
                        ptr       <= grant_idx_q + IDX_W'(1);
                        hold_cnt  <= '0;
                        // timeout only when neither done nor a dropped request caused release
                        timeout_q <= !bus.done && owner_req;
                        state     <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    decoder_2to4 u_decoder (
        .sel    (grant_idx_q),
        .onehot (onehot)
    );

    assign bus.grant     = busy_q ? onehot : '0;
    assign bus.grant_idx = grant_idx_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with MAX_HOLD=4 and hand-computed expectations.
module tb_rr_arbiter_4;
    import rr_arbiter_4_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(
        .MAX_HOLD (4),
        .CNT_W    (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic b, input logic t);
        check_eq({tag, ".grant"},   32'(bus.grant),   32'(g));
        check_eq({tag, ".busy"},    32'(bus.busy),    32'(b));
        check_eq({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;

        // Reset, no clock edge yet
        #3;
        check_out("rst_async", 4'b0000, 1'b0, 1'b0);
        check_eq("rst_idx", 32'(bus.grant_idx), 32'd0);
        step();
        step();
        check_out("rst_held", 4'b0000, 1'b0, 1'b0);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        step();
        step();
        check_out("idle_noreq", 4'b0000, 1'b0, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check_out("done_idle", 4'b0000, 1'b0, 1'b0);

        // Single grant
        bus.req = 4'b0001;
        step();
        check_out("single", 4'b0001, 1'b1, 1'b0);
        check_eq("single.idx", 32'(bus.grant_idx), 32'd0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check_out("single_rel", 4'b0000, 1'b0, 1'b0);
        step();
        check_out("single_gap", 4'b0000, 1'b0, 1'b0);
        step();
        check_out("single_regrant", 4'b0001, 1'b1, 1'b0);
        bus.req = 4'b0000;
        step();
        check_out("drop_rel", 4'b0000, 1'b0, 1'b0);
        step();

        // Round robin from ptr=0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("rr%0d", k), rr_exp[k], 1'b1, 1'b0);
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            check_out($sformatf("rr%0d_rel", k), 4'b0000, 1'b0, 1'b0);
            step();
            check_out($sformatf("rr%0d_gap", k), 4'b0000, 1'b0, 1'b0);
        end
        bus.req = 4'b0000;
        step();
        // ptr=1 here

        // Hold timeout on client 2
        bus.req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_out($sformatf("hold%0d", c), 4'b0100, 1'b1, 1'b0);
        end
        step();
        check_out("timeout", 4'b0000, 1'b0, 1'b1);
        bus.req = 4'b1100;
        step();
        check_out("timeout_clr", 4'b0000, 1'b0, 1'b0);
        step();
        check_out("after_to", 4'b1000, 1'b1, 1'b0);
        check_eq("after_to.idx", 32'(bus.grant_idx), 32'd3);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        step();
        // ptr=0, IDLE

        // done on the 4th grant cycle wins over timeout
        bus.req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_out($sformatf("coll%0d", c), 4'b0001, 1'b1, 1'b0);
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check_out("coll_done", 4'b0000, 1'b0, 1'b0);
        bus.req = 4'b0000;
        step();

        // owner drops req on the 4th grant cycle, ptr=1
        bus.req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_out($sformatf("drop%0d", c), 4'b0010, 1'b1, 1'b0);
        end
        bus.req = 4'b0000;
        step();
        check_out("coll_drop", 4'b0000, 1'b0, 1'b0);
        step();
        // ptr=2, IDLE

        // Async reset mid-grant
        bus.req = 4'b0010;
        step();
        check_out("pre_rst", 4'b0010, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 4'b0000, 1'b0, 1'b0);
        #2;
        rst_n   = 1'b1;
        bus.req = 4'b0011;
        step();
        check_out("post_rst", 4'b0001, 1'b1, 1'b0);
        check_eq("post_rst.idx", 32'(bus.grant_idx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter_4
